cpu_host_param: RTL and testbench

//  Parametrised successor of the 16-bit CPU host: configurable data/PC/LFSR widths, valid/ready

---
 rtl/cpu_host_param.sv | 191 +++++++++++++++++++
 tb/tb_cpu_host_param.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_host_param.sv
// cpu_host_param: parametrised 16-bit-instruction host core with 8 GPRs, a Fibonacci LFSR,
// a valid/ready instruction handshake and a bit-serial shifter.
//
// Optional feature: define CPU_HOST_RESUME_EN to add the `resume` input, which leaves HALT,
// resumes at PC+1 and clears cpu_halt. Without it, HALT is left only through pon_rst_n_i.
//
// Ports:
//   clk           in   clock, rising edge
//   pon_rst_n_i   in   asynchronous active-low reset
//   instruction   in   [15:12] op, [11:9] rd, [6:4] rs1, [2:0] rs2, [7:0] imm8, [3:0] shamt
//   instr_valid   in   instruction present
//   resume        in   (CPU_HOST_RESUME_EN only) leave HALT
//   instr_ready   out  core accepts; transfer on valid && ready
//   pc_out        out  PC, registered (one cycle behind)
//   reg_data_out  out  GPR[OUT_REG], registered
//   lfsr_out      out  current LFSR state
//   busy          out  multi-cycle shift in progress
//   cpu_halt      out  HALT executed
module cpu_host_param #(
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       PC_W      = 13,
  parameter int unsigned       LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_INIT = LFSR_W'(16'h1000),
  parameter logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(16'hB400),
  parameter int unsigned       OUT_REG   = 6
) (
  input  logic              clk,
  input  logic              pon_rst_n_i,
  input  logic [15:0]       instruction,
  input  logic              instr_valid,
`ifdef CPU_HOST_RESUME_EN
  input  logic              resume,
`endif
  output logic              instr_ready,
  output logic [PC_W-1:0]   pc_out,
  output logic [DATA_W-1:0] reg_data_out,
  output logic [LFSR_W-1:0] lfsr_out,
  output logic              busy,
  output logic              cpu_halt
);

  typedef enum logic [1:0] {StRun, StShift, StHalt} state_e;

  localparam logic [3:0] OpAdd  = 4'h1;
  localparam logic [3:0] OpSub  = 4'h2;
  localparam logic [3:0] OpOr   = 4'h3;
  localparam logic [3:0] OpLdi  = 4'h4;
  localparam logic [3:0] OpAnd  = 4'h5;
  localparam logic [3:0] OpXor  = 4'h6;
  localparam logic [3:0] OpShl  = 4'h7;
  localparam logic [3:0] OpShr  = 4'h8;
  localparam logic [3:0] OpLfr  = 4'h9;
  localparam logic [3:0] OpBeqz = 4'hC;
  localparam logic [3:0] OpJmp  = 4'hD;
  localparam logic [3:0] OpHalt = 4'hF;

  localparam logic [2:0] OutIdx = 3'(OUT_REG);

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d, pc_out_q;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [DATA_W-1:0]   gpr_q [8];
  logic [DATA_W-1:0]   gpr_d [8];
  logic [DATA_W-1:0]   reg_out_q;
  logic [DATA_W-1:0]   sh_val_q, sh_val_d;
  logic [3:0]          sh_cnt_q, sh_cnt_d;
  logic [2:0]          sh_rd_q, sh_rd_d;
  logic                sh_left_q, sh_left_d;

  logic [3:0]          op;
  logic [2:0]          rd;
  logic [7:0]          imm8;
  logic [3:0]          shamt;
  logic [DATA_W-1:0]   rs1_val, rs2_val;
  logic [PC_W-1:0]     pc_inc;
  logic [LFSR_W-1:0]   lfsr_step;

  assign op        = instruction[15:12];
  assign rd        = instruction[11:9];
  assign imm8      = instruction[7:0];
  assign shamt     = instruction[3:0];
  assign rs1_val   = gpr_q[instruction[6:4]];
  assign rs2_val   = gpr_q[instruction[2:0]];
  assign pc_inc    = pc_q + PC_W'(1);
  assign lfsr_step = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};

  // State and datapath registers
  always_ff @(posedge clk or negedge pon_rst_n_i) begin
    if (!pon_rst_n_i) begin
      state_q   <= StRun;
      pc_q      <= '0;
      pc_out_q  <= '0;
      lfsr_q    <= LFSR_INIT;
      reg_out_q <= '0;
      sh_val_q  <= '0;
      sh_cnt_q  <= '0;
      sh_rd_q   <= '0;
      sh_left_q <= 1'b0;
      for (int i = 0; i < 8; i++) gpr_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pc_out_q  <= pc_q;
      lfsr_q    <= lfsr_d;
      reg_out_q <= gpr_q[OutIdx];
      sh_val_q  <= sh_val_d;
      sh_cnt_q  <= sh_cnt_d;
      sh_rd_q   <= sh_rd_d;
      sh_left_q <= sh_left_d;
      for (int i = 0; i < 8; i++) gpr_q[i] <= gpr_d[i];
    end
  end

  // Next-state and execute
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    lfsr_d    = lfsr_q;
    gpr_d     = gpr_q;
    sh_val_d  = sh_val_q;
    sh_cnt_d  = sh_cnt_q;
    sh_rd_d   = sh_rd_q;
    sh_left_d = sh_left_q;
    unique case (state_q)
      StRun: begin
        if (instr_valid) begin
          lfsr_d = lfsr_step;
          pc_d   = pc_inc;
          case (op)
            OpAdd:  gpr_d[rd] = rs1_val + rs2_val;
            OpSub:  gpr_d[rd] = rs1_val - rs2_val;
            OpOr:   gpr_d[rd] = rs1_val | rs2_val;
            OpAnd:  gpr_d[rd] = rs1_val & rs2_val;
            OpXor:  gpr_d[rd] = rs1_val ^ rs2_val;
            OpLdi:  gpr_d[rd] = DATA_W'(imm8);
            OpLfr:  gpr_d[rd] = DATA_W'(lfsr_q);
            OpShl, OpShr: begin
              if (shamt == 4'd0) begin
                gpr_d[rd] = rs1_val;
              end else begin
                // PC advances together with the rd write on the last shift cycle
                state_d   = StShift;
                pc_d      = pc_q;
                sh_val_d  = rs1_val;
                sh_cnt_d  = shamt;
                sh_rd_d   = rd;
                sh_left_d = (op == OpShl);
              end
            end
            OpBeqz: if (gpr_q[rd] == '0) pc_d = pc_q + PC_W'($signed(imm8));
            OpJmp:  pc_d = PC_W'(instruction[11:0]);
            OpHalt: begin
              state_d = StHalt;
              pc_d    = pc_q;
            end
            default: ;
          endcase
        end
      end
      StShift: begin
        sh_val_d = sh_left_q ? (sh_val_q << 1) : (sh_val_q >> 1);
        sh_cnt_d = sh_cnt_q - 4'd1;
        if (sh_cnt_q == 4'd1) begin
          gpr_d[sh_rd_q] = sh_val_d;
          pc_d           = pc_inc;
          state_d        = StRun;
        end
      end
      StHalt: begin
`ifdef CPU_HOST_RESUME_EN
        if (resume) begin
          state_d = StRun;
          pc_d    = pc_inc;
        end
`endif
      end
      default: state_d = StRun;
    endcase
  end

  // Outputs
  always_comb begin
    instr_ready  = (state_q == StRun);
    busy         = (state_q == StShift);
    cpu_halt     = (state_q == StHalt);
    pc_out       = pc_out_q;
    reg_data_out = reg_out_q;
    lfsr_out     = lfsr_q;
  end

endmodule

// File: tb/tb_cpu_host_param.sv
module tb_cpu_host_param;

  localparam int unsigned PcW = 12;

  logic            clk = 1'b0;
  logic            pon_rst_n_i = 1'b0;
  logic [15:0]     instruction = '0;
  logic            instr_valid = 1'b0;
`ifdef CPU_HOST_RESUME_EN
  logic            resume = 1'b0;
`endif
  logic            instr_ready;
  logic [PcW-1:0]  pc_out;
  logic [15:0]     reg_data_out;
  logic [15:0]     lfsr_out;
  logic            busy;
  logic            cpu_halt;

  cpu_host_param #(
    .PC_W(PcW)
  ) u_dut (
    .clk          (clk),
    .pon_rst_n_i  (pon_rst_n_i),
    .instruction  (instruction),
    .instr_valid  (instr_valid),
`ifdef CPU_HOST_RESUME_EN
    .resume       (resume),
`endif
    .instr_ready  (instr_ready),
    .pc_out       (pc_out),
    .reg_data_out (reg_data_out),
    .lfsr_out     (lfsr_out),
    .busy         (busy),
    .cpu_halt     (cpu_halt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [15:0]    m_gpr [8];
  logic [PcW-1:0] m_pc;
  logic [15:0]    m_lfsr;

  typedef struct {
    logic [PcW-1:0] pc;
    logic [15:0]    r6;
    logic [15:0]    lfsr;
    int             busy_n;
  } exp_t;

  exp_t sb [$];

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_gpr[i] = '0;
    m_pc   = '0;
    m_lfsr = 16'h1000;
  endfunction

  function automatic int model_exec(input logic [15:0] ins);
    logic [3:0]     op;
    logic [2:0]     rd;
    logic [15:0]    a, b, lf_old;
    logic [7:0]     imm;
    logic [3:0]     sh;
    logic [PcW-1:0] npc;
    int             bn;
    op     = ins[15:12];
    rd     = ins[11:9];
    a      = m_gpr[ins[6:4]];
    b      = m_gpr[ins[2:0]];
    imm    = ins[7:0];
    sh     = ins[3:0];
    lf_old = m_lfsr;
    m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
    npc    = m_pc + 1'b1;
    bn     = 0;
    case (op)
      4'h1: m_gpr[rd] = a + b;
      4'h2: m_gpr[rd] = a - b;
      4'h3: m_gpr[rd] = a | b;
      4'h4: m_gpr[rd] = {8'h00, imm};
      4'h5: m_gpr[rd] = a & b;
      4'h6: m_gpr[rd] = a ^ b;
      4'h7: begin m_gpr[rd] = a << sh; bn = int'(sh); end
      4'h8: begin m_gpr[rd] = a >> sh; bn = int'(sh); end
      4'h9: m_gpr[rd] = lf_old;
      4'hC: if (m_gpr[rd] == 16'h0) npc = m_pc + {{(PcW-8){imm[7]}}, imm};
      4'hD: npc = ins[11:0];
      4'hF: npc = m_pc;
      default: ;
    endcase
    m_pc = npc;
    return bn;
  endfunction

  // Drive one instruction, push its expectation, wait for completion and score it.
  task automatic issue(input string tag, input logic [15:0] ins);
    exp_t e;
    int   busy_n;
    int   low_n;
    int   waited;
    e.busy_n = model_exec(ins);
    e.pc     = m_pc;
    e.r6     = m_gpr[6];
    e.lfsr   = m_lfsr;
    sb.push_back(e);
    @(negedge clk);
    check({tag, ".ready_in"}, 32'(instr_ready), 32'd1);
    instruction = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instruction = '0;
    busy_n = 0;
    low_n  = 0;
    waited = 0;
    while (!instr_ready && !cpu_halt && waited < 40) begin
      if (busy) busy_n++;
      low_n++;
      @(posedge clk);
      #1;
      waited++;
    end
    if (waited >= 40) check({tag, ".timeout"}, 32'd1, 32'd0);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({tag, ".pc"},   32'(pc_out),       32'(e.pc));
    check({tag, ".r6"},   32'(reg_data_out), 32'(e.r6));
    check({tag, ".lfsr"}, 32'(lfsr_out),     32'(e.lfsr));
    if (!cpu_halt) begin
      check({tag, ".busy_n"}, 32'(busy_n), 32'(e.busy_n));
      check({tag, ".low_n"},  32'(low_n),  32'(e.busy_n));
    end
  endtask

  initial begin
    model_reset();
    #12;
    check("rst.async_ready", 32'(instr_ready), 32'd1);
    pon_rst_n_i = 1'b1;
    @(posedge clk);
    #1;
    check("rst.pc",    32'(pc_out),       32'd0);
    check("rst.r6",    32'(reg_data_out), 32'd0);
    check("rst.ready", 32'(instr_ready),  32'd1);
    check("rst.lfsr",  32'(lfsr_out),     32'h1000);
    check("rst.busy",  32'(busy),         32'd0);
    check("rst.halt",  32'(cpu_halt),     32'd0);

    issue("ldi_r6", 16'h4C5A);
    issue("ldi_r1", 16'h420F);
    issue("xor",    16'h6C61);
    check("xor.r6_const", 32'(reg_data_out), 32'h0055);
    check("xor.pc_const", 32'(pc_out),       32'd3);
    issue("ldi_r2", 16'h4481);
    issue("shl4",   16'h7C24);
    check("shl4.r6_const", 32'(reg_data_out), 32'h0810);
    issue("beqz_t", 16'hC0FE);
    check("beqz_t.pc_const", 32'(pc_out), 32'd3);
    issue("shr3",   16'h8C63);
    issue("shl0",   16'h7C20);
    issue("add",    16'h1C21);
    issue("sub",    16'h2C12);
    issue("or",     16'h3C21);
    issue("and",    16'h5C21);
    issue("lfr",    16'h9C00);
    issue("beqz_n", 16'hC405);
    issue("op_e",   16'hEC21);
    issue("rdrs",   16'h1C66);
    issue("jmp",    16'hDFFF);
    check("jmp.pc_const", 32'(pc_out), 32'h0FFF);
    issue("nop_wr", 16'h0000);
    check("wrap.pc_const", 32'(pc_out), 32'd0);
    issue("shl15",  16'h7C2F);

    // HALT: valid is ignored and LFSR frozen afterwards
    issue("halt", 16'hF000);
    check("halt.flag",  32'(cpu_halt),    32'd1);
    check("halt.ready", 32'(instr_ready), 32'd0);
    @(negedge clk);
    instruction = 16'h4CFF;
    instr_valid = 1'b1;
    repeat (5) @(negedge clk);
    instr_valid = 1'b0;
    instruction = '0;
    @(posedge clk);
    #1;
    check("halt.pc_hold",   32'(pc_out),       32'(m_pc));
    check("halt.lfsr_hold", 32'(lfsr_out),     32'(m_lfsr));
    check("halt.r6_hold",   32'(reg_data_out), 32'(m_gpr[6]));
    check("halt.still",     32'(cpu_halt),     32'd1);
`ifdef CPU_HOST_RESUME_EN
    @(negedge clk);
    resume = 1'b1;
    @(posedge clk);
    #1;
    resume = 1'b0;
    check("resume.halt",  32'(cpu_halt),    32'd0);
    check("resume.ready", 32'(instr_ready), 32'd1);
    m_pc = m_pc + 1'b1;
    @(posedge clk);
    #1;
    check("resume.pc", 32'(pc_out), 32'(m_pc));
    issue("resume_ldi", 16'h4C33);
`endif

    // Reset in the middle of a shift: rd stays at its reset value
    pon_rst_n_i = 1'b0;
    #7;
    pon_rst_n_i = 1'b1;
    model_reset();
    issue("r_ldi_r2", 16'h4481);
    @(negedge clk);
    instruction = 16'h7C28;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instruction = '0;
    @(posedge clk);
    #2;
    check("mid.busy_pre", 32'(busy), 32'd1);
    pon_rst_n_i = 1'b0;
    #1;
    check("mid.busy",  32'(busy),         32'd0);
    check("mid.ready", 32'(instr_ready),  32'd1);
    check("mid.pc",    32'(pc_out),       32'd0);
    check("mid.lfsr",  32'(lfsr_out),     32'h1000);
    check("mid.r6",    32'(reg_data_out), 32'd0);
    @(negedge clk);
    pon_rst_n_i = 1'b1;
    model_reset();
    repeat (10) @(posedge clk);
    #1;
    check("mid.r6_after", 32'(reg_data_out), 32'd0);
    check("mid.pc_after", 32'(pc_out),       32'd0);
    issue("post_nop", 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
